// File: rtl/argmin_chunk_sched_if.sv
// ---------------------------------------------------------------------------
// argmin_chunk_sched_if
//   Bundles the three data paths of argmin_chunk_sched: the incoming cost
//   beats, the side port to the shared argmin_10 pipeline, and the result
//   stream.
//
//   Handshake semantics (in_* and out_* streams): a transfer happens on a
//   rising clk edge where valid && ready are both 1. A source holding valid
//   keeps its payload stable until the transfer. ready never depends on the
//   same stream's valid, so there are no combinational valid->ready loops.
//
//   Modports
//     slave  : the scheduler's view (consumes beats, produces results)
//     master : the environment's view (census stage, argmin_10, sink)
// ---------------------------------------------------------------------------
interface argmin_chunk_sched_if #(
  parameter int WIDTH  = 32,
  parameter int CHUNKS = 4,
  parameter int IDX_W  = $clog2(10 * CHUNKS)
);
  logic                  in_valid;
  logic                  in_ready;
  logic [10*WIDTH-1:0]   in_costs;
  logic [10*WIDTH-1:0]   am_inp;
  logic [WIDTH-1:0]      am_outp;
  logic [4:0]            am_addr;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_cost;
  logic [IDX_W-1:0]      out_idx;

  modport slave (
    input  in_valid, in_costs, am_outp, am_addr, out_ready,
    output in_ready, am_inp, out_valid, out_cost, out_idx
  );

  modport master (
    output in_valid, in_costs, am_outp, am_addr, out_ready,
    input  in_ready, am_inp, out_valid, out_cost, out_idx
  );
endinterface

// File: rtl/argmin_chunk_sched.sv
// ---------------------------------------------------------------------------
// argmin_chunk_sched
//   Runs a 10*CHUNKS-candidate disparity cost search through a shared
//   10-lane pipelined argmin_10. Each pixel arrives as CHUNKS beats of ten
//   costs; every beat is registered onto am_inp, a tag follows it through
//   the argmin latency, the per-beat winners are folded into one global
//   (min cost, index), and finished pixels land in a small result FIFO.
//   Credits (pixels started + FIFO occupancy) keep the FIFO from ever
//   overflowing while the output is back-pressured.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset (also resets argmin_10)
//   bus.in_*       cost beat stream (in_costs lane k at [k*WIDTH +: WIDTH])
//   bus.am_inp     registered beat costs to argmin_10
//   bus.am_outp    argmin_10 minimum cost, ARGMIN_LAT after am_inp
//   bus.am_addr    argmin_10 winning lane 0..9
//   bus.out_*      result stream: out_cost, out_idx = chunk*10 + lane
// ---------------------------------------------------------------------------
module argmin_chunk_sched #(
  parameter int WIDTH      = 32,
  parameter int CHUNKS     = 4,
  parameter int ARGMIN_LAT = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int IDX_W      = $clog2(10 * CHUNKS)
) (
  input  logic                 clk,
  input  logic                 rst,
  argmin_chunk_sched_if.slave  bus
);

  localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW = $clog2(FIFO_DEPTH + 1);

  localparam logic [CW-1:0] LAST_BEAT = CW'(CHUNKS - 1);
  localparam logic [NW-1:0] FULL_LVL  = NW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_LAST  = PW'(FIFO_DEPTH - 1);

  typedef struct packed {
    logic          vld;
    logic          first;
    logic          last;
    logic [CW-1:0] chunk;
  } tag_t;

  // ---- state ----
  logic [CW-1:0]       r_bcnt;
  logic [NW-1:0]       r_cred;
  logic [10*WIDTH-1:0] r_am_inp;
  tag_t                r_tag [0:ARGMIN_LAT];
  logic [WIDTH-1:0]    r_acc_cost;
  logic [IDX_W-1:0]    r_acc_idx;
  logic [WIDTH-1:0]    r_mem_cost [0:FIFO_DEPTH-1];
  logic [IDX_W-1:0]    r_mem_idx  [0:FIFO_DEPTH-1];
  logic [PW-1:0]       r_wptr;
  logic [PW-1:0]       r_rptr;
  logic [NW-1:0]       r_count;

  // ---- combinational ----
  logic             w_in_ready;
  logic             w_accept;
  logic             w_first;
  logic             w_last;
  logic             w_out_valid;
  logic             w_pop;
  tag_t             w_tag_in;
  tag_t             w_tag_out;
  logic [IDX_W-1:0] w_cand_idx;
  logic             w_take;
  logic [WIDTH-1:0] w_new_cost;
  logic [IDX_W-1:0] w_new_idx;
  logic             w_push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // A pixel already started is never stalled for credit; only a first beat
  // needs a free credit. rst forces ready low so nothing is taken in reset.
  assign w_first    = (r_bcnt == '0);
  assign w_last     = (r_bcnt == LAST_BEAT);
  assign w_in_ready = !rst && (!w_first || (r_cred < FULL_LVL));
  assign w_accept   = bus.in_valid && w_in_ready;

  assign w_out_valid = (r_count != '0);
  assign w_pop       = w_out_valid && bus.out_ready;

  always_comb begin
    w_tag_in       = '0;
    w_tag_in.vld   = w_accept;
    w_tag_in.first = w_first;
    w_tag_in.last  = w_last;
    w_tag_in.chunk = r_bcnt;
  end

  // The tag leaving the last stage lines up with am_outp/am_addr: one cycle
  // for the am_inp register plus ARGMIN_LAT cycles inside argmin_10.
  assign w_tag_out  = r_tag[ARGMIN_LAT];
  assign w_cand_idx = IDX_W'(w_tag_out.chunk) * IDX_W'(10) + IDX_W'(bus.am_addr);

  // Strict compare: on a tie the earlier chunk (lower index) is kept.
  assign w_take     = w_tag_out.first || (bus.am_outp < r_acc_cost);
  assign w_new_cost = w_take ? bus.am_outp : r_acc_cost;
  assign w_new_idx  = w_take ? w_cand_idx  : r_acc_idx;
  assign w_push     = w_tag_out.vld && w_tag_out.last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bcnt     <= '0;
      r_cred     <= '0;
      r_am_inp   <= '0;
      r_acc_cost <= '0;
      r_acc_idx  <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      for (int i = 0; i <= ARGMIN_LAT; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_am_inp <= bus.in_costs;
        r_bcnt   <= w_last ? '0 : r_bcnt + 1'b1;
      end

      r_tag[0] <= w_tag_in;
      for (int i = 1; i <= ARGMIN_LAT; i++) begin
        r_tag[i] <= r_tag[i-1];
      end

      case ({w_accept && w_first, w_pop})
        2'b10:   r_cred <= r_cred + 1'b1;
        2'b01:   r_cred <= r_cred - 1'b1;
        default: r_cred <= r_cred;
      endcase

      if (w_tag_out.vld) begin
        r_acc_cost <= w_new_cost;
        r_acc_idx  <= w_new_idx;
      end

      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      // Credits make a push into a full, non-draining FIFO impossible.
      assert (!(w_push && (r_count == FULL_LVL) && !w_pop));
    end
  end

  // Storage needs no reset: the outputs are gated by out_valid.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem_cost[r_wptr] <= w_new_cost;
      r_mem_idx[r_wptr]  <= w_new_idx;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.am_inp    = r_am_inp;
  assign bus.out_valid = w_out_valid;
  assign bus.out_cost  = w_out_valid ? r_mem_cost[r_rptr] : '0;
  assign bus.out_idx   = w_out_valid ? r_mem_idx[r_rptr]  : '0;

endmodule

// File: tb/tb_argmin_chunk_sched.sv
// ---------------------------------------------------------------------------
// tb_argmin_chunk_sched
//   Bench for argmin_chunk_sched with a behavioural argmin_10 (4-cycle
//   pipelined lane argmin, lowest lane wins ties) attached to the am_* port.
//   Expected results come from a table of hand-computed pixels and from a
//   plain loop over all 10*CHUNKS candidates for random pixels.
// ---------------------------------------------------------------------------
module tb_argmin_chunk_sched;

  localparam int W   = 32;
  localparam int CH  = 4;
  localparam int LAT = 4;
  localparam int DEP = 4;
  localparam int IW  = $clog2(10 * CH);
  localparam int NC  = 10 * CH;
  localparam int EW  = W + IW;

  typedef struct {
    logic [W-1:0] base;
    int           pa;
    logic [W-1:0] va;
    int           pb;
    logic [W-1:0] vb;
    logic [W-1:0] ec;
    int           ei;
  } vec_t;

  logic clk;
  logic rst;

  argmin_chunk_sched_if #(.WIDTH(W), .CHUNKS(CH)) bus_if ();

  argmin_chunk_sched #(
    .WIDTH(W), .CHUNKS(CH), .ARGMIN_LAT(LAT), .FIFO_DEPTH(DEP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int             n_vec = 0;
  int             n_err = 0;
  logic [EW-1:0]  exp_q[$];
  logic [W-1:0]   pix [0:NC-1];
  vec_t           tbl [10];
  int             rdy_mode = 0;   // 0: out_ready low, 1: high, 2: random
  bit             no_stall = 1'b0;
  int             tb_bcnt = 0;
  int             tb_started = 0;
  logic [EW-1:0]  got;

  // ---------------- argmin_10 model ----------------
  logic [W+4:0] am_s [0:LAT-1];

  function automatic logic [W+4:0] am10(input logic [10*W-1:0] c);
    logic [W-1:0] bc;
    logic [4:0]   ba;
    bc = c[W-1:0];
    ba = 5'd0;
    for (int k = 1; k < 10; k++) begin
      if (c[k*W +: W] < bc) begin
        bc = c[k*W +: W];
        ba = 5'(k);
      end
    end
    return {ba, bc};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) am_s[i] <= '0;
    end else begin
      am_s[0] <= am10(bus_if.am_inp);
      for (int i = 1; i < LAT; i++) am_s[i] <= am_s[i-1];
    end
  end

  assign bus_if.am_outp = am_s[LAT-1][W-1:0];
  assign bus_if.am_addr = am_s[LAT-1][W+4:W];

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] ref_argmin();
    logic [W-1:0] bc;
    int           bi;
    bc = pix[0];
    bi = 0;
    for (int i = 1; i < NC; i++) begin
      if (pix[i] < bc) begin
        bc = pix[i];
        bi = i;
      end
    end
    return {bc, IW'(bi)};
  endfunction

  // ---------------- output ready driver ----------------
  initial begin
    bus_if.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       bus_if.out_ready = 1'b1;
        2:       bus_if.out_ready = 1'($urandom_range(0, 1));
        default: bus_if.out_ready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  // Sampled mid-cycle: whatever is seen here is what the next edge acts on.
  always @(negedge clk) begin
    if (rst) begin
      tb_bcnt    = 0;
      tb_started = 0;
    end else begin
      if (bus_if.in_valid) begin
        n_vec++;
        if (!bus_if.in_ready && (tb_bcnt != 0 || no_stall)) begin
          n_err++;
          $display("FAIL in_ready_stall: in_ready=0 at beat %0d (no_stall=%0d), required 1",
                   tb_bcnt, no_stall);
        end
        if (bus_if.in_ready) begin
          if (tb_bcnt == 0) tb_started++;
          tb_bcnt = (tb_bcnt == CH - 1) ? 0 : tb_bcnt + 1;
        end
      end
      if (bus_if.out_valid) begin
        n_vec++;
        got = {bus_if.out_cost, bus_if.out_idx};
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL result_extra: got cost=%0h idx=%0d, required none", got[EW-1:IW], got[IW-1:0]);
        end else begin
          if (got !== exp_q[0]) begin
            n_err++;
            $display("FAIL result: got cost=%0h idx=%0d, required cost=%0h idx=%0d",
                     got[EW-1:IW], got[IW-1:0], exp_q[0][EW-1:IW], exp_q[0][IW-1:0]);
          end
          if (bus_if.out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic send_beat(input logic [10*W-1:0] c, output bit ok);
    int n;
    n = 0;
    bus_if.in_valid = 1'b1;
    bus_if.in_costs = c;
    while (!bus_if.in_ready && n < 200) begin
      cyc();
      n++;
    end
    if (!bus_if.in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL beat_timeout: in_ready=0 for %0d cycles, required 1", n);
      ok = 1'b0;
    end else begin
      cyc();
      ok = 1'b1;
    end
  endtask

  task automatic make_beat(input int b, output logic [10*W-1:0] beat);
    for (int k = 0; k < 10; k++) beat[k*W +: W] = pix[b*10 + k];
  endtask

  // Sends the pixel held in pix[]; exp is queued once the last beat is taken.
  task automatic send_pixel(input logic [EW-1:0] expv, input int gap_max, output bit ok);
    logic [10*W-1:0] beat;
    bit              okb;
    int              g;
    ok = 1'b1;
    for (int b = 0; b < CH; b++) begin
      if (gap_max > 0) begin
        g = $urandom_range(0, gap_max);
        bus_if.in_valid = 1'b0;
        repeat (g) cyc();
      end
      make_beat(b, beat);
      send_beat(beat, okb);
      if (!okb) begin
        bus_if.in_valid = 1'b0;
        ok = 1'b0;
        return;
      end
    end
    bus_if.in_valid = 1'b0;
    exp_q.push_back(expv);
  endtask

  task automatic load_tbl(input int i);
    for (int c = 0; c < NC; c++) pix[c] = tbl[i].base;
    pix[tbl[i].pa] = tbl[i].va;
    pix[tbl[i].pb] = tbl[i].vb;
  endtask

  task automatic rand_pix();
    bit narrow;
    narrow = 1'($urandom_range(0, 1));
    for (int c = 0; c < NC; c++) pix[c] = narrow ? W'($urandom_range(0, 15)) : $urandom;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      cyc();
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // ---------------- main test ----------------
  initial begin
    bit              ok;
    int              n;
    int              done;
    logic [10*W-1:0] beat;

    tbl[0] = '{32'd100,        27, 32'd5,        27, 32'd5,        32'd5,        27};
    tbl[1] = '{32'd100,         4, 32'd3,        33, 32'd3,        32'd3,         4};
    tbl[2] = '{32'hFFFF_FFFF,   0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0};
    tbl[3] = '{32'd50,         39, 32'd0,         0, 32'd1,        32'd0,        39};
    tbl[4] = '{32'd7,          10, 32'd7,         9, 32'd6,        32'd6,         9};
    tbl[5] = '{32'd2,           0, 32'd2,        39, 32'd2,        32'd2,         0};
    tbl[6] = '{32'd9,          30, 32'd8,        31, 32'd8,        32'd8,        30};
    tbl[7] = '{32'd1000,       19, 32'd999,      20, 32'd998,      32'd998,      20};
    tbl[8] = '{32'd64,         11, 32'd0,        12, 32'd0,        32'd0,        11};
    tbl[9] = '{32'd80,          3, 32'd70,       13, 32'd70,       32'd70,        3};

    rst             = 1'b1;
    bus_if.in_valid = 1'b0;
    bus_if.in_costs = '0;
    repeat (3) cyc();

    // Reset state
    chk("rst_in_ready",  bus_if.in_ready, 0);
    chk("rst_out_valid", bus_if.out_valid, 0);
    chk("rst_out_cost",  bus_if.out_cost, 0);
    chk("rst_out_idx",   bus_if.out_idx, 0);
    chk("rst_am_inp",    64'(bus_if.am_inp == '0), 1);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", bus_if.in_ready, 1);

    // Single pixel with latency measurement
    rdy_mode = 1;
    cyc();
    load_tbl(0);
    send_pixel({tbl[0].ec, IW'(tbl[0].ei)}, 0, ok);
    n = 0;
    while (!bus_if.out_valid && n < 50) begin
      cyc();
      n++;
    end
    chk("latency", n, LAT + 1);
    drain("drain_single");

    // Table vectors, back-to-back
    for (int i = 1; i < 10; i++) begin
      load_tbl(i);
      send_pixel({tbl[i].ec, IW'(tbl[i].ei)}, 0, ok);
    end
    drain("drain_table");

    // Backpressure: 8 pixels offered with out_ready low
    rdy_mode   = 0;
    cyc();
    tb_started = 0;
    done       = 0;
    fork
      begin
        for (int p = 0; p < 8; p++) begin
          rand_pix();
          send_pixel(ref_argmin(), 0, ok);
          if (ok) done++;
        end
      end
      begin
        repeat (60) cyc();
        chk("bp_started",   tb_started, DEP);
        chk("bp_out_valid", bus_if.out_valid, 1);
        chk("bp_in_ready",  bus_if.in_ready, 0);
        rdy_mode = 1;
      end
    join
    chk("bp_completed", done, 8);
    drain("drain_bp");

    // 16 random pixels back-to-back, sink always ready: no stall allowed
    no_stall = 1'b1;
    for (int p = 0; p < 16; p++) begin
      rand_pix();
      send_pixel(ref_argmin(), 0, ok);
    end
    no_stall = 1'b0;
    drain("drain_stream");

    // Random gaps and random sink readiness
    rdy_mode = 2;
    for (int p = 0; p < 16; p++) begin
      rand_pix();
      send_pixel(ref_argmin(), 2, ok);
    end
    rdy_mode = 1;
    drain("drain_random");

    // Reset mid-pixel with two pixels in flight
    rdy_mode = 0;
    cyc();
    rand_pix();
    send_pixel(ref_argmin(), 0, ok);
    rand_pix();
    for (int b = 0; b < 2; b++) begin
      make_beat(b, beat);
      send_beat(beat, ok);
    end
    bus_if.in_valid = 1'b0;
    rst = 1'b1;
    cyc();
    chk("midrst_out_valid", bus_if.out_valid, 0);
    chk("midrst_cred",      dut.r_cred, 0);
    chk("midrst_in_ready",  bus_if.in_ready, 0);
    exp_q.delete();
    rst = 1'b0;
    #1;
    chk("midrst_in_ready_after", bus_if.in_ready, 1);
    rdy_mode = 1;
    cyc();
    load_tbl(1);
    send_pixel({tbl[1].ec, IW'(tbl[1].ei)}, 0, ok);
    drain("drain_after_rst");
    repeat (20) cyc();
    chk("after_rst_idle", bus_if.out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
